// File: rtl/mux_sync_tx.sv
// Source side of the mux-based CDC path: holds a word on xfer_data, raises xfer_en as a
// level request and runs a four-phase handshake against a synchronized ack from the far side.
module mux_sync_tx #(
  parameter int WIDTH          = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk1,
  input  logic             rst1,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_en,
  input  logic             ack_async,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  input  logic             err_clr,
  output logic             err_timeout
);

  localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [SET_W-1:0] SETUP_INIT = SET_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_DROP} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [SET_W-1:0]       r_setup_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [TO_W-1:0]        w_to_inc;
  logic [WIDTH-1:0]       r_xfer_data;
  logic                   r_xfer_en;
  logic                   r_done;
  logic [CNT_W-1:0]       r_xfer_count;
  logic                   r_err_timeout;
  logic                   w_ack_sync;
  logic                   w_accept;
  logic                   w_waiting;
  logic                   w_enter_req;
  logic                   w_complete;

  assign w_ack_sync  = r_ack_sync[SYNC_STAGES-1];
  assign src_ready   = (r_state == S_IDLE) && !w_ack_sync;
  assign w_accept    = src_valid && src_ready;
  assign w_waiting   = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_enter_req = (w_state_next == S_REQ) && (r_state != S_REQ);
  assign w_complete  = (r_state == S_DROP) && !w_ack_sync;
  assign w_to_inc    = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + TO_W'(1);

  assign xfer_data   = r_xfer_data;
  assign xfer_en     = r_xfer_en;
  assign done        = r_done;
  assign busy        = (r_state != S_IDLE);
  assign xfer_count  = r_xfer_count;
  assign err_timeout = r_err_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_SETUP;
      S_SETUP: if (r_setup_cnt == '0) w_state_next = S_REQ;
      S_REQ:   if (w_ack_sync) w_state_next = S_DROP;
      S_DROP:  if (!w_ack_sync) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst1) begin
      r_state       <= S_IDLE;
      r_ack_sync    <= '0;
      r_setup_cnt   <= '0;
      r_to_cnt      <= '0;
      r_xfer_data   <= '0;
      r_xfer_en     <= 1'b0;
      r_done        <= 1'b0;
      r_xfer_count  <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
      // Registered from the next state so the enable is a clean flop output.
      r_xfer_en  <= (w_state_next == S_REQ);
      r_done     <= w_complete;
      if (w_complete) r_xfer_count <= r_xfer_count + CNT_W'(1);

      if (w_accept) begin
        r_xfer_data <= src_data;
        r_setup_cnt <= SETUP_INIT;
      end else if ((r_state == S_SETUP) && (r_setup_cnt != '0)) begin
        r_setup_cnt <= r_setup_cnt - SET_W'(1);
      end

      if (w_enter_req) r_to_cnt <= '0;
      else if (w_waiting) r_to_cnt <= w_to_inc;

      // A set in the same cycle as err_clr takes priority.
      if (w_waiting && (w_to_inc == TO_MAX)) r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
    end
  end

endmodule
